// File: rtl/gpio_pad_ctrl.sv
// Per-channel GPIO pad control: push-pull/open-drain drive, synchronised and
// glitch-filtered inputs, and edge-detect interrupt status behind a small register port.
module gpio_pad_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [2:0]        cfg_addr,
    input  logic [NUM_CH-1:0] cfg_wdata,
    output logic [NUM_CH-1:0] cfg_rdata,
    input  logic [NUM_CH-1:0] pad_in,
    output logic [NUM_CH-1:0] pad_out,
    output logic [NUM_CH-1:0] pad_oe,
    output logic              irq
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_OE      = 3'd1;
    localparam logic [2:0] ADDR_OD      = 3'd2;
    localparam logic [2:0] ADDR_IN      = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_IRQ     = 3'd6;
    localparam logic [2:0] ADDR_THRESH  = 3'd7;

    localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] oe_q, oe_d;
    logic [NUM_CH-1:0] od_q, od_d;
    logic [NUM_CH-1:0] rise_en_q, rise_en_d;
    logic [NUM_CH-1:0] fall_en_q, fall_en_d;
    logic [NUM_CH-1:0] irq_status_q, irq_status_d;
    logic [FILT_W-1:0] thresh_q, thresh_d;
    logic [NUM_CH-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] filt_q, filt_d;
    logic [NUM_CH-1:0] filt_dly_q;
    logic [FILT_W-1:0] cnt_q [NUM_CH];
    logic [FILT_W-1:0] cnt_d [NUM_CH];

    logic [7:0]        wr_sel;
    logic [NUM_CH-1:0] synced;
    logic [NUM_CH-1:0] rise_evt;
    logic [NUM_CH-1:0] fall_evt;
    logic [NUM_CH-1:0] w1c_mask;
    logic [NUM_CH-1:0] rd_val;

    assign synced = sync_q[SYNC_STAGES-1];

    // Open-drain channels only ever pull low: enable the driver when OUT is 0.
    always_comb begin
        pad_out = out_q & ~od_q;
        pad_oe  = oe_q & ~(od_q & out_q);
    end

    assign cfg_rdata = rdata_q;
    assign irq       = irq_q;

    always_comb begin
        wr_sel = '0;
        if (cfg_we) begin
            wr_sel = 8'b1 << cfg_addr;
        end
    end

    always_comb begin
        out_d     = wr_sel[ADDR_OUT]     ? cfg_wdata : out_q;
        oe_d      = wr_sel[ADDR_OE]      ? cfg_wdata : oe_q;
        od_d      = wr_sel[ADDR_OD]      ? cfg_wdata : od_q;
        rise_en_d = wr_sel[ADDR_RISE_EN] ? cfg_wdata : rise_en_q;
        fall_en_d = wr_sel[ADDR_FALL_EN] ? cfg_wdata : fall_en_q;
        thresh_d  = wr_sel[ADDR_THRESH]  ? cfg_wdata[FILT_W-1:0] : thresh_q;
    end

    // Status bits: W1C clear first, new edge events OR'd in last so a set wins.
    always_comb begin
        rise_evt     = filt_q & ~filt_dly_q & rise_en_q;
        fall_evt     = ~filt_q & filt_dly_q & fall_en_q;
        w1c_mask     = wr_sel[ADDR_IRQ] ? cfg_wdata : '0;
        irq_status_d = (irq_status_q & ~w1c_mask) | rise_evt | fall_evt;
        irq_d        = |irq_status_q;
    end

    always_comb begin
        rd_val = '0;
        unique case (cfg_addr)
            ADDR_OUT:     rd_val = out_q;
            ADDR_OE:      rd_val = oe_q;
            ADDR_OD:      rd_val = od_q;
            ADDR_IN:      rd_val = filt_q;
            ADDR_RISE_EN: rd_val = rise_en_q;
            ADDR_FALL_EN: rd_val = fall_en_q;
            ADDR_IRQ:     rd_val = irq_status_q;
            ADDR_THRESH:  rd_val[FILT_W-1:0] = thresh_q;
            default:      rd_val = '0;
        endcase
        rdata_d = cfg_re ? rd_val : rdata_q;
    end

    // A mismatch has to survive THRESH+1 consecutive cycles before filt follows it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (synced[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thresh_q) begin
                filt_d[i] = synced[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            oe_q         <= '0;
            od_q         <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            thresh_q     <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
            filt_q       <= '0;
            filt_dly_q   <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q        <= out_d;
            oe_q         <= oe_d;
            od_q         <= od_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            thresh_q     <= thresh_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
            filt_q       <= filt_d;
            filt_dly_q   <= filt_q;
            sync_q[0]    <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a behavioural model.
module tb_gpio_pad_ctrl;

    localparam int NUM_CH      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 4;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic              cfg_re;
    logic [2:0]        cfg_addr;
    logic [7:0]        cfg_wdata;
    logic [7:0]        cfg_rdata;
    logic [7:0]        pad_in;
    logic [7:0]        pad_out;
    logic [7:0]        pad_oe;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    gpio_pad_ctrl #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: registers as plain variables, the pad path as a delay line
    // of raw samples, and per-channel mismatch run lengths for the filter.
    logic [7:0] m_out, m_oe, m_od, m_rise, m_fall, m_stat, m_rdata, m_filt, m_filt_prev;
    logic [3:0] m_thr;
    logic       m_irq;
    logic [7:0] m_hist [SYNC_STAGES];
    int         m_run [NUM_CH];

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_out;
            3'd1: return m_oe;
            3'd2: return m_od;
            3'd3: return m_filt;
            3'd4: return m_rise;
            3'd5: return m_fall;
            3'd6: return m_stat;
            default: return {4'b0, m_thr};
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] s, nfilt, setb, clr;
        if (rst) begin
            {m_out, m_oe, m_od, m_rise, m_fall, m_stat, m_rdata, m_filt, m_filt_prev} = '0;
            m_thr = '0;
            m_irq = 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
            for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
        end else begin
            if (cfg_re) m_rdata = model_read(cfg_addr);
            m_irq = (m_stat != 0);
            setb  = (m_filt & ~m_filt_prev & m_rise) | (~m_filt & m_filt_prev & m_fall);
            clr   = (cfg_we && cfg_addr == 3'd6) ? cfg_wdata : 8'h00;
            s     = m_hist[SYNC_STAGES-1];
            nfilt = m_filt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (s[i] == m_filt[i]) m_run[i] = 0;
                else if (m_run[i] >= int'(m_thr)) begin
                    nfilt[i] = s[i];
                    m_run[i] = 0;
                end else m_run[i] = m_run[i] + 1;
            end
            m_filt_prev = m_filt;
            m_filt      = nfilt;
            m_stat      = (m_stat & ~clr) | setb;
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = pad_in;
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0: m_out  = cfg_wdata;
                    3'd1: m_oe   = cfg_wdata;
                    3'd2: m_od   = cfg_wdata;
                    3'd4: m_rise = cfg_wdata;
                    3'd5: m_fall = cfg_wdata;
                    3'd7: m_thr  = cfg_wdata[3:0];
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        {m_out, m_oe, m_od, m_rise, m_fall, m_stat, m_rdata, m_filt, m_filt_prev} = '0;
        m_thr = '0;
        m_irq = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
        for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("model_pad_out", {24'b0, pad_out}, {24'b0, m_out & ~m_od});
            chk("model_pad_oe", {24'b0, pad_oe}, {24'b0, m_oe & ~(m_od & m_out)});
            chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
            chk("model_rdata", {24'b0, cfg_rdata}, {24'b0, m_rdata});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        cfg_re = 1'b1; cfg_addr = a;
        @(negedge clk);
        cfg_re = 1'b0;
        chk(name, {24'b0, cfg_rdata}, {24'b0, exp});
    endtask

    initial begin
        logic [7:0] flip;
        rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        pad_in = 8'hFF;
        tick(3);
        chk("reset_rdata", {24'b0, cfg_rdata}, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_oe", {24'b0, pad_oe}, 32'h0);
        rst = 1'b0;
        tick(3);
        rd(3'd3, 8'hFF, "in_after_reset");
        rd(3'd6, 8'h00, "status_after_reset");
        chk("irq_after_reset", {31'b0, irq}, 32'h0);
        chk("oe_after_reset", {24'b0, pad_oe}, 32'h0);

        wr(3'd0, 8'hA5); wr(3'd1, 8'hFF); wr(3'd2, 8'h0F);
        chk("drive_pad_out", {24'b0, pad_out}, 32'hA0);
        chk("drive_pad_oe", {24'b0, pad_oe}, 32'hFA);

        wr(3'd7, 8'h03);
        rd(3'd7, 8'h03, "thresh_readback");
        pad_in = 8'h00;
        tick(10);
        for (int k = 1; k <= 12; k++) begin
            pad_in[0] = (k <= 3);
            rd(3'd3, 8'h00, "pulse3_blocked");
        end
        for (int k = 1; k <= 12; k++) begin
            pad_in[0] = (k <= 4);
            rd(3'd3, (k >= 7 && k <= 10) ? 8'h01 : 8'h00, "pulse4_latency");
        end

        wr(3'd7, 8'h00); wr(3'd4, 8'h01); wr(3'd5, 8'h01);
        pad_in[0] = 1'b1; tick(4);
        pad_in[0] = 1'b0; tick(6);
        rd(3'd6, 8'h01, "status_after_edges");
        chk("irq_after_edges", {31'b0, irq}, 32'h1);
        wr(3'd6, 8'h01);
        rd(3'd6, 8'h00, "status_after_w1c");
        chk("irq_after_w1c", {31'b0, irq}, 32'h0);

        pad_in[0] = 1'b1; tick(3);
        wr(3'd6, 8'h01);
        rd(3'd6, 8'h01, "set_beats_clear");

        wr(3'd4, 8'h03);
        pad_in = 8'h03; tick(5);
        rd(3'd6, 8'h03, "status_two_bits");
        wr(3'd7, 8'h03);
        pad_in = 8'h07; tick(4);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        chk("midrst_oe", {24'b0, pad_oe}, 32'h0);
        chk("midrst_out", {24'b0, pad_out}, 32'h0);
        chk("midrst_rdata", {24'b0, cfg_rdata}, 32'h0);
        rd(3'd0, 8'h00, "midrst_out_reg");
        rd(3'd1, 8'h00, "midrst_oe_reg");
        rd(3'd2, 8'h00, "midrst_od_reg");
        rd(3'd4, 8'h00, "midrst_rise_reg");
        rd(3'd5, 8'h00, "midrst_fall_reg");
        rd(3'd6, 8'h00, "midrst_status_reg");
        rd(3'd7, 8'h00, "midrst_thresh_reg");
        tick(6);
        rd(3'd6, 8'h00, "midrst_edge_discarded");

        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_re    = ($urandom_range(0, 1) == 0);
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_wdata = (cfg_addr == 3'd7) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            flip      = 8'($urandom) & 8'($urandom) & 8'($urandom);
            pad_in    = pad_in ^ flip;
            @(negedge clk);
        end
        rst = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
